pla_sweep_ctrl: RTL and testbench
=================================

PLA_SWEEP_CTRL -- requirements
Module: pla_sweep_ctrl

Interface
REQ-001 Parameter NIN, default 7, number of function inputs driven (x0..x(NIN-1)).
REQ-002 Parameter LAT, default 0, range 0..7, cycles from x_o change to the matching y_i being valid.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a sweep; ignored unless state is IDLE.
REQ-006 fix_mask  input  NIN  1 = input is fixed (restricted), 0 = input is free; sampled with start.
REQ-007 fix_val  input  NIN  values of the fixed inputs; bits where fix_mask=0 are ignored; sampled with start.
REQ-008 x_o  output  NIN  input vector presented to the combinational function under test (bit i drives xi).
REQ-009 y_i  input  1  function output y0 for the vector issued LAT cycles earlier.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  one-cycle pulse when a sweep completes.
REQ-012 onset_cnt  output  NIN+1  count of sampled vectors with y_i=1 in the last or current sweep.
REQ-013 sig  output  16  MISR signature of the y_i stream; present only with PLA_SWEEP_SIG_EN.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE: start=1 -> latch mask/val, clear onset_cnt, seed sig to 0xFFFF, set x_o = fix_val & fix_mask, go to RUN.
REQ-016 RUN: x_o is held for exactly one cycle per vector; each RUN cycle issues one vector and pushes a 1 into a LAT-deep valid pipeline.
REQ-017 Enumeration: next free bits = (((x_o | fix_mask) + 1) & ~fix_mask); fixed bits keep fix_val; order is ascending binary over the free bits.
REQ-018 Vector count is exactly 2^(number of zero bits in fix_mask); fix_mask all ones issues one vector; fix_mask all zeros issues 2^NIN.
REQ-019 The vector with all free bits = 1 is the last one; after issuing it -> DRAIN, with x_o holding that vector.
REQ-020 LAT=0: y_i is sampled in the same cycle its vector is on x_o; LAT=k: sampled k cycles later via the valid pipeline.
REQ-021 Each valid sample: onset_cnt += y_i; width NIN+1 does not wrap (max 2^NIN).
REQ-022 DRAIN: exits to DONE in the cycle after the valid pipeline is empty; LAT=0 spends zero cycles in DRAIN (RUN -> DONE directly).
REQ-023 DONE: done=1 for one cycle, then -> IDLE; onset_cnt and sig hold their values until the next accepted start.
REQ-024 Timing: with start accepted at edge 0 and N vectors, done is high in cycle N+LAT+1.
REQ-025 start while busy or in DONE has no effect, and mask/val changes during a sweep have no effect.

Reset
REQ-026 rst=1 -> state IDLE, x_o=0, busy=0, done=0, onset_cnt=0, valid pipeline cleared, sig=0xFFFF.
REQ-027 rst during RUN/DRAIN aborts the sweep: no done pulse, partial results are discarded.
REQ-028 rst has priority over start in the same cycle.

Configuration
REQ-029 Macro PLA_SWEEP_SIG_EN defined: sig port exists; 16-bit MISR, polynomial 0x1021, shifts left with feedback = sig[15] ^ y_i on every valid sample.
REQ-030 Macro undefined: no sig port and no MISR logic; all other behaviour is identical.

Structure
REQ-031 Package pla_sweep_pkg holds the state enum, the NIN default, MISR_POLY=16'h1021 and MISR_SEED=16'hFFFF.
REQ-032 The MISR is the sub-module pla_sweep_misr (ports clk, rst, seed_load, shift_en, bit_in, sig), instantiated only under PLA_SWEEP_SIG_EN.

Verification
REQ-033 y_i tied 1, fix_mask=0, LAT=0, start -> 128 vectors 0..127 on x_o, onset_cnt=128, done in cycle 129.
REQ-034 fix_mask=7'b0000101, fix_val=7'b0000001, y_i=x_o[1], LAT=2 -> 32 vectors, all with x0=1 and x2=0, onset_cnt=16, done in cycle 35.
REQ-035 fix_mask=7'h7F, fix_val=7'h55 -> one vector 0x55, done in cycle 2 (LAT=0).
REQ-036 rst asserted mid-RUN at vector 40 -> IDLE next cycle, no done, onset_cnt=0; a new start then completes normally.
REQ-037 start pulsed repeatedly while busy -> the sweep is unaffected and exactly one done pulse occurs.
REQ-038 PLA_SWEEP_SIG_EN, y_i tied 0, fix_mask=0 -> sig equals the golden-model MISR value for 128 zeros; without the macro, sig is absent and the build is clean.

Source files
------------

// File: rtl/pla_sweep_pkg.sv
// Shared types and constants for the PLA sweep controller.
// Build option PLA_SWEEP_SIG_EN enables the MISR signature port.
package pla_sweep_pkg;
  localparam int          NIN_DEF   = 7;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/pla_sweep_misr.sv
// 16-bit MISR compacting the sampled y stream; used when PLA_SWEEP_SIG_EN is defined.
module pla_sweep_misr
  import pla_sweep_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic        shift_en,
  input  logic        bit_in,
  output logic [15:0] sig
);
  logic [15:0] sig_q, sig_d;
  logic        fb;

  always_comb begin
    sig_d = sig_q;
    fb    = sig_q[15] ^ bit_in;
    if (seed_load) begin
      sig_d = MISR_SEED;
    end else if (shift_en) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= MISR_SEED;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;
endmodule

// File: rtl/pla_sweep_ctrl.sv
// Sweeps all free-input combinations of a PLA, counting onset vectors of y_i.
// Build option PLA_SWEEP_SIG_EN adds the sig output (MISR over the y_i samples).
module pla_sweep_ctrl
  import pla_sweep_pkg::*;
#(
  parameter int NIN = NIN_DEF,
  parameter int LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [NIN-1:0] fix_mask,
  input  logic [NIN-1:0] fix_val,
  output logic [NIN-1:0] x_o,
  input  logic           y_i,
  output logic           busy,
  output logic           done,
  output logic [NIN:0]   onset_cnt,
`ifdef PLA_SWEEP_SIG_EN
  output logic [15:0]    sig,
`endif
  output state_e         dbg_state
);
  state_e         state_q, state_d;
  logic [NIN-1:0] x_q, x_d, mask_q, mask_d, val_q, val_d;
  logic [NIN:0]   onset_q, onset_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           issue, sample_vld, pipe_empty_nxt, last_vec;

  assign issue    = (state_q == S_RUN);
  assign last_vec = &(x_q | mask_q);

  // Valid pipeline: a 1 enters per issued vector and emerges LAT cycles later.
  if (LAT == 0) begin : g_nopipe
    assign sample_vld     = issue;
    assign pipe_empty_nxt = 1'b1;
  end else begin : g_pipe
    logic [LAT-1:0] pipe_q, pipe_d;
    if (LAT == 1) begin : g_one
      always_comb pipe_d = issue;
    end else begin : g_multi
      always_comb pipe_d = {pipe_q[LAT-2:0], issue};
    end
    always_ff @(posedge clk) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= pipe_d;
    end
    assign sample_vld     = pipe_q[LAT-1];
    assign pipe_empty_nxt = (pipe_d == '0);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mask_d  = mask_q;
    val_d   = val_q;
    onset_d = onset_q;
    if (sample_vld) onset_d = onset_q + (NIN+1)'(y_i);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = fix_mask;
          val_d   = fix_val & fix_mask;
          x_d     = fix_val & fix_mask;
          onset_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_vec) begin
          state_d = (LAT == 0) ? S_DONE : S_DRAIN;
        end else begin
          // Carry ripples through fixed positions because they are forced to 1.
          x_d = (((x_q | mask_q) + {{(NIN-1){1'b0}}, 1'b1}) & ~mask_q) | val_q;
        end
      end
      S_DRAIN: if (pipe_empty_nxt) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      mask_q  <= '0;
      val_q   <= '0;
      onset_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mask_q  <= mask_d;
      val_q   <= val_d;
      onset_q <= onset_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PLA_SWEEP_SIG_EN
  logic seed_load;
  assign seed_load = (state_q == S_IDLE) && start;

  pla_sweep_misr u_misr (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .shift_en  (sample_vld),
    .bit_in    (y_i),
    .sig       (sig)
  );
`endif

  assign x_o       = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign onset_cnt = onset_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Bench for pla_sweep_ctrl: a LAT=0 and a LAT=2 instance swept side by side against a truth-table model.
// Define PLA_SWEEP_SIG_EN to also check the MISR signature.
module tb_pla_sweep_ctrl;
  import pla_sweep_pkg::*;

  localparam int NIN = 7;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [NIN-1:0] fix_mask, fix_val;
  logic [NIN-1:0] x0, x2, xd1, xd2;
  logic           y0, y2, busy0, busy2, done0, done2;
  logic [NIN:0]   onset0, onset2;
  state_e         st0, st2;
`ifdef PLA_SWEEP_SIG_EN
  logic [15:0]    sig0, sig2;
`endif

  logic [1:0]     y_mode;
  logic [127:0]   tbl;
  logic [7:0]     exp_q[$];
  int             exp_ones;
  logic [15:0]    exp_sig;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  // y model: 0 = random truth table, 1 = tied 1, 2 = tied 0, 3 = x1
  function automatic logic yfun(input logic [NIN-1:0] v, input logic [1:0] mode,
                                input logic [127:0] t);
    case (mode)
      2'd0:    return t[v];
      2'd1:    return 1'b1;
      2'd2:    return 1'b0;
      default: return v[1];
    endcase
  endfunction

  assign y0 = yfun(x0, y_mode, tbl);
  assign y2 = yfun(xd2, y_mode, tbl);

  // The LAT=2 instance sees the function result of the vector issued two cycles earlier.
  always @(posedge clk) begin
    xd1 <= x2;
    xd2 <= xd1;
  end

  pla_sweep_ctrl #(.NIN(NIN), .LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .fix_mask(fix_mask), .fix_val(fix_val),
    .x_o(x0), .y_i(y0), .busy(busy0), .done(done0), .onset_cnt(onset0),
`ifdef PLA_SWEEP_SIG_EN
    .sig(sig0),
`endif
    .dbg_state(st0)
  );

  pla_sweep_ctrl #(.NIN(NIN), .LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .fix_mask(fix_mask), .fix_val(fix_val),
    .x_o(x2), .y_i(y2), .busy(busy2), .done(done2), .onset_cnt(onset2),
`ifdef PLA_SWEEP_SIG_EN
    .sig(sig2),
`endif
    .dbg_state(st2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected vectors: every input value whose fixed bits match, in ascending order.
  task automatic build_model(input logic [NIN-1:0] mask, input logic [NIN-1:0] val);
    logic y;
    exp_q.delete();
    exp_ones = 0;
    exp_sig  = 16'hFFFF;
    for (int v = 0; v < 128; v++) begin
      if ((v[NIN-1:0] & mask) == (val & mask)) begin
        exp_q.push_back(8'(v));
        y = yfun(v[NIN-1:0], y_mode, tbl);
        exp_ones += int'(y);
        exp_sig = (exp_sig << 1) ^ ((exp_sig[15] ^ y) ? 16'h1021 : 16'h0000);
      end
    end
  endtask

  task automatic run_sweep(input string name, input logic [NIN-1:0] mask,
                           input logic [NIN-1:0] val, input logic [1:0] mode, input bit noise);
    int n, dc0, dc2, p0, p2;
    y_mode = mode;
    build_model(mask, val);
    n = exp_q.size();
    @(negedge clk);
    fix_mask = mask;
    fix_val  = val;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc0 = -1; dc2 = -1; p0 = 0; p2 = 0;
    for (int c = 1; c <= n + 6; c++) begin
      if (c <= n) begin
        chk({name, "_x0"}, 32'(x0), 32'(exp_q[c-1]));
        chk({name, "_x2"}, 32'(x2), 32'(exp_q[c-1]));
      end else if (c <= n + 2) begin
        chk({name, "_x2_hold"}, 32'(x2), 32'(exp_q[n-1]));
      end
      if (done0) begin p0++; if (dc0 < 0) dc0 = c; end
      if (done2) begin p2++; if (dc2 < 0) dc2 = c; end
      if (noise && c < n) begin
        start    = 1'($urandom_range(0, 1));
        fix_mask = NIN'($urandom);
        fix_val  = NIN'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk({name, "_done_cyc0"}, 32'(dc0), 32'(n + 1));
    chk({name, "_done_cyc2"}, 32'(dc2), 32'(n + 3));
    chk({name, "_pulses0"}, 32'(p0), 32'd1);
    chk({name, "_pulses2"}, 32'(p2), 32'd1);
    chk({name, "_onset0"}, 32'(onset0), 32'(exp_ones));
    chk({name, "_onset2"}, 32'(onset2), 32'(exp_ones));
    chk({name, "_idle"}, {30'd0, busy0, busy2}, 32'd0);
`ifdef PLA_SWEEP_SIG_EN
    chk({name, "_sig0"}, 32'(sig0), 32'(exp_sig));
    chk({name, "_sig2"}, 32'(sig2), 32'(exp_sig));
`endif
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; fix_mask = '0; fix_val = '0; y_mode = 2'd2; tbl = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_x", 32'(x0), 32'd0);
    chk("rst_busy_done", {30'd0, busy0, done0}, 32'd0);
    chk("rst_onset", 32'(onset0), 32'd0);
    chk("rst_state", 32'(st0), 32'(S_IDLE));
`ifdef PLA_SWEEP_SIG_EN
    chk("rst_sig", 32'(sig0), 32'hFFFF);
`endif

    run_sweep("full_ones", 7'h00, 7'h00, 2'd1, 1'b0);
    run_sweep("x1_fixed", 7'b0000101, 7'b0000001, 2'd3, 1'b0);
    run_sweep("all_fixed", 7'h7F, 7'h55, 2'd0, 1'b0);
    run_sweep("zeros", 7'h00, 7'h00, 2'd2, 1'b0);

    for (int i = 0; i < 4; i++) begin
      tbl = {$urandom, $urandom, $urandom, $urandom};
      run_sweep("rand", NIN'($urandom), NIN'($urandom), 2'd0, i[0]);
    end

    // Abort a sweep with reset in the middle of RUN.
    y_mode = 2'd1;
    @(negedge clk);
    fix_mask = '0; fix_val = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 32'(st0), 32'(S_IDLE));
    chk("abort_busy", {30'd0, busy0, busy2}, 32'd0);
    chk("abort_onset", 32'(onset0) + 32'(onset2), 32'd0);
    chk("abort_x", 32'(x0), 32'd0);
    pulses = 0;
    for (int c = 0; c < 140; c++) begin
      if (done0 || done2) pulses++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    tbl = {$urandom, $urandom, $urandom, $urandom};
    run_sweep("after_abort", 7'b1000010, 7'b0000010, 2'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
